bytes8_word32: RTL and testbench



---
 rtl/bytes8_word32.sv | 103 ++++++++++
 tb/tb_bytes8_word32.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bytes8_word32.sv
// Byte-to-word packer: gathers four consecutive valid bytes on clk_4f into one 32-bit word.
// Optional macro BYTES8_WORD32_PARTIAL_ERR_EN adds a partial_err pulse on aborted words.
module bytes8_word32 #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [7:0]  Data_in,
    output logic        valid_out,
    output logic [31:0] Data_out
`ifdef BYTES8_WORD32_PARTIAL_ERR_EN
    ,
    output logic        partial_err
`endif
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;      // bytes 0..2, oldest in the top byte
    logic [31:0] data_q, data_d;
    logic        vld_q, vld_d;
    logic [31:0] word_asm;

    assign word_asm = LSB_FIRST ? {Data_in, sh_q[7:0], sh_q[15:8], sh_q[23:16]}
                                : {sh_q, Data_in};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    sh_d    = {16'h0, Data_in};
                    cnt_d   = 2'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (valid_in) begin
                    if (cnt_q == 2'd3) begin
                        data_d  = word_asm;
                        vld_d   = 1'b1;
                        cnt_d   = 2'd0;
                        sh_d    = 24'h0;
                        state_d = IDLE;
                    end else begin
                        sh_d  = {sh_q[15:0], Data_in};
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    // gap inside a word: drop what was collected
                    cnt_d   = 2'd0;
                    sh_d    = 24'h0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = 2'd0;
                sh_d    = 24'h0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            sh_q    <= 24'h0;
            data_q  <= 32'h0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    assign valid_out = vld_q;
    assign Data_out  = data_q;

`ifdef BYTES8_WORD32_PARTIAL_ERR_EN
    logic perr_q, perr_d;

    assign perr_d = (state_q == COLLECT) && !valid_in;

    always_ff @(posedge clk_4f) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end

    assign partial_err = perr_q;
`endif

endmodule

// File: tb/tb_bytes8_word32.sv
// Bench for bytes8_word32: MSB-first and LSB-first instances share one byte stream and are
// compared every cycle against a queue-based model of the packing rules.
module tb_bytes8_word32;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin;
    logic [7:0]  din;
    logic        vo_m, vo_l;
    logic [31:0] do_m, do_l;
`ifdef BYTES8_WORD32_PARTIAL_ERR_EN
    logic        pe_m, pe_l;
`endif

    always #5 clk = ~clk;

    bytes8_word32 #(.LSB_FIRST(1'b0)) u_msb (
        .clk_4f(clk), .reset(rst), .valid_in(vin), .Data_in(din),
        .valid_out(vo_m), .Data_out(do_m)
`ifdef BYTES8_WORD32_PARTIAL_ERR_EN
        , .partial_err(pe_m)
`endif
    );

    bytes8_word32 #(.LSB_FIRST(1'b1)) u_lsb (
        .clk_4f(clk), .reset(rst), .valid_in(vin), .Data_in(din),
        .valid_out(vo_l), .Data_out(do_l)
`ifdef BYTES8_WORD32_PARTIAL_ERR_EN
        , .partial_err(pe_l)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: bytes of the word in progress, plus expected registered outputs
    logic [7:0]  q[$];
    logic [31:0] exp_m, exp_l;
    logic        exp_v, exp_pe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst = r; vin = v; din = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_m = 32'h0; exp_l = 32'h0; exp_v = 1'b0; exp_pe = 1'b0;
        end else if (v) begin
            exp_pe = 1'b0;
            q.push_back(d);
            if (q.size() == 4) begin
                exp_m = {q[0], q[1], q[2], q[3]};
                exp_l = {q[3], q[2], q[1], q[0]};
                exp_v = 1'b1;
                q.delete();
            end else begin
                exp_v = 1'b0;
            end
        end else begin
            exp_pe = (q.size() != 0);
            exp_v  = 1'b0;
            q.delete();
        end
        #1;
        chk("msb_valid", {31'h0, vo_m}, {31'h0, exp_v});
        chk("msb_data",  do_m, exp_m);
        chk("lsb_valid", {31'h0, vo_l}, {31'h0, exp_v});
        chk("lsb_data",  do_l, exp_l);
`ifdef BYTES8_WORD32_PARTIAL_ERR_EN
        chk("msb_perr", {31'h0, pe_m}, {31'h0, exp_pe});
        chk("lsb_perr", {31'h0, pe_l}, {31'h0, exp_pe});
`endif
    endtask

    // serializer order: MSB byte first
    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, w[8*i +: 8]);
    endtask

    logic [31:0] lb_words [3];

    initial begin
        rst = 1'b1; vin = 1'b0; din = 8'h0;
        exp_m = 32'h0; exp_l = 32'h0; exp_v = 1'b0; exp_pe = 1'b0;

        // reset state
        step(1'b1, 1'b0, 8'h00);
        chk("rst_data", do_m, 32'h0);
        chk("rst_valid", {31'h0, vo_m}, 32'h0);

        // single word, then back-to-back pair
        step(1'b0, 1'b0, 8'h00);
        send_word(32'hFFAAFFBB);
        chk("tp1_word", do_m, 32'hFFAAFFBB);
        chk("tp1_strobe", {31'h0, vo_m}, 32'h1);
        step(1'b0, 1'b0, 8'h00);
        chk("tp1_after", {31'h0, vo_m}, 32'h0);
        send_word(32'hFFAAFFBB);
        send_word(32'hDDCCDDEE);
        chk("b2b_word2", do_m, 32'hDDCCDDEE);

        // idle gap holds last word
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
        chk("gap_hold", do_m, 32'hDDCCDDEE);
        send_word(32'h010F0A03);
        chk("gap_word", do_m, 32'h010F0A03);

        // partial word aborted by a gap
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b0, 8'h00);
        chk("abort_hold", do_m, 32'h010F0A03);
`ifdef BYTES8_WORD32_PARTIAL_ERR_EN
        chk("abort_perr", {31'h0, pe_m}, 32'h1);
        step(1'b0, 1'b1, 8'h0A);
        chk("abort_perr_clr", {31'h0, pe_m}, 32'h0);
        step(1'b0, 1'b1, 8'h0B);
        step(1'b0, 1'b1, 8'h0C);
        step(1'b0, 1'b1, 8'h0D);
`else
        send_word(32'h0A0B0C0D);
`endif
        chk("abort_word", do_m, 32'h0A0B0C0D);

        // reset mid-word with a valid byte present during reset
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b1, 1'b1, 8'h99);
        chk("midrst_data", do_m, 32'h0);
        chk("midrst_lsb", do_l, 32'h0);
        send_word(32'h33445566);
        chk("midrst_word", do_m, 32'h33445566);

        // LSB-first ordering
        step(1'b0, 1'b1, 8'hBB);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 8'hFF);
        chk("lsb_word", do_l, 32'hFFAAFFBB);

        // loopback: serializer-ordered words recovered in order
        lb_words[0] = 32'hFFAAFFBB; lb_words[1] = 32'hDDCCDDEE; lb_words[2] = 32'h010F0A03;
        for (int i = 0; i < 3; i++) begin
            send_word(lb_words[i]);
            chk("loopback", do_m, lb_words[i]);
        end

        // random stream with gaps and occasional resets
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, 8'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
